// File: rtl/n3_seq_pkg.sv
// n3_seq_pkg: state encoding and default widths for the zero-skipping window sequencer
package n3_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam int N_DEF = 16;
  localparam int TN_DEF = 16;
  localparam int ADDR_DEF = 16;
  localparam int LEN_DEF = 16;
endpackage

// File: rtl/n3_lane_seq.sv
// n3_lane_seq: one lane's region pointer, non-zero count, overflow flag and write register
module n3_lane_seq #(
  parameter int N = 16,
  parameter int ADDR_SIZE = 16,
  parameter int LEN_W = 16,
  parameter int LANE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [ADDR_SIZE-1:0] base,
  input  logic [ADDR_SIZE-1:0] stride_in,
  input  logic [ADDR_SIZE-1:0] stride,
  input  logic [N-1:0]         data,
  input  logic [N-1:0]         off,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [N-1:0]         wr_val,
  output logic [N-1:0]         wr_off,
  output logic [LEN_W-1:0]     cnt,
  output logic                 ovf
);
  logic [ADDR_SIZE-1:0] rbase;
  logic [ADDR_SIZE:0]   idx;
  logic                 nz, fits, wr;
  assign nz = |data;
  // idx carries one extra bit so idx+2 against the stride never wraps
  assign fits = (idx + (ADDR_SIZE+1)'(2)) <= {1'b0, stride};
  assign wr = accept & nz & fits;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_val <= '0;
      wr_off <= '0;
      rbase <= '0;
      idx <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      wr_en <= wr;
      if (wr) begin
        wr_addr <= rbase + idx[ADDR_SIZE-1:0];
        wr_val <= data;
        wr_off <= off;
      end
      if (clear) begin
        rbase <= base + ADDR_SIZE'(LANE) * stride_in;
        idx <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (wr) begin
        idx <= idx + (ADDR_SIZE+1)'(2);
        cnt <= cnt + LEN_W'(1);
      end else if (accept & nz) begin
        ovf <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/n3_seq_ctrl.sv
// n3_seq_ctrl: sequences one compression window of Tn-lane bricks into per-lane (value, offset) writes
module n3_seq_ctrl
  import n3_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Tn = TN_DEF,
  parameter int ADDR_SIZE = ADDR_DEF,
  parameter int LEN_W = LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len,
  input  logic [ADDR_SIZE-1:0]    i_base_addr,
  input  logic [ADDR_SIZE-1:0]    i_lane_stride,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [Tn*N-1:0]         i_data,
  input  logic                    i_wr_ready,
  output logic [Tn-1:0]           o_wr_en,
  output logic [Tn*ADDR_SIZE-1:0] o_wr_addr,
  output logic [Tn*N-1:0]         o_wr_val,
  output logic [Tn*N-1:0]         o_wr_off,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [Tn*LEN_W-1:0]     o_cnt,
  output logic [Tn-1:0]           o_ovf
);
  state_t               state, nxt;
  logic [LEN_W-1:0]     len_q, beat;
  logic [ADDR_SIZE-1:0] stride_q;
  logic [N-1:0]         off;
  logic                 clear, accept, last;
  assign clear = (state == S_IDLE) & i_start;
  assign o_ready = (state == S_RUN) & i_wr_ready;
  assign accept = i_valid & o_ready;
  assign last = accept & (beat == len_q - LEN_W'(1));
  assign off = N'(beat);
  assign o_busy = state != S_IDLE;
  assign o_done = state == S_DONE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = i_start ? (i_len == '0 ? S_DONE : S_RUN) : S_IDLE;
      S_RUN: nxt = last ? S_DONE : S_RUN;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      len_q <= '0;
      stride_q <= '0;
      beat <= '0;
    end else begin
      state <= nxt;
      if (clear) begin
        len_q <= i_len;
        stride_q <= i_lane_stride;
        beat <= '0;
      end else if (accept) begin
        beat <= beat + LEN_W'(1);
      end
    end
  end
  for (genvar k = 0; k < Tn; k++) begin : g_lane
    n3_lane_seq #(.N(N), .ADDR_SIZE(ADDR_SIZE), .LEN_W(LEN_W), .LANE(k)) u_lane (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .accept(accept),
      .base(i_base_addr),
      .stride_in(i_lane_stride),
      .stride(stride_q),
      .data(i_data[k*N +: N]),
      .off(off),
      .wr_en(o_wr_en[k]),
      .wr_addr(o_wr_addr[k*ADDR_SIZE +: ADDR_SIZE]),
      .wr_val(o_wr_val[k*N +: N]),
      .wr_off(o_wr_off[k*N +: N]),
      .cnt(o_cnt[k*LEN_W +: LEN_W]),
      .ovf(o_ovf[k])
    );
  end
endmodule

// File: tb/tb_n3_seq_ctrl.sv
// tb_n3_seq_ctrl: randomized windows checked against a queue-based model of the encoder
module tb_n3_seq_ctrl;
  localparam int N = 16, TN = 16, A = 16, L = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 1'b0, i_valid = 1'b0, i_wr_ready = 1'b0;
  logic [L-1:0] i_len = '0;
  logic [A-1:0] i_base_addr = '0, i_lane_stride = '0;
  logic [TN*N-1:0] i_data = '0;
  logic o_ready, o_busy, o_done;
  logic [TN-1:0] o_wr_en, o_ovf;
  logic [TN*A-1:0] o_wr_addr;
  logic [TN*N-1:0] o_wr_val, o_wr_off;
  logic [TN*L-1:0] o_cnt;

  n3_seq_ctrl #(.N(N), .Tn(TN), .ADDR_SIZE(A), .LEN_W(L)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_base_addr(i_base_addr),
    .i_lane_stride(i_lane_stride), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_wr_ready(i_wr_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_val(o_wr_val),
    .o_wr_off(o_wr_off), .o_busy(o_busy), .o_done(o_done), .o_cnt(o_cnt), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {int lane; int addr; int val; int off; longint cyc;} wr_t;
  wr_t exp_q[$];
  logic [TN*N-1:0] bq[$];
  int n_cmp = 0, n_bad = 0;
  longint cyc = 0;
  int m_base, m_stride;
  int m_idx[TN], m_cnt[TN];
  bit m_ovf[TN];
  int g_stall = -1, g_abort = -1, g_start = -1;

  always @(posedge clk) cyc++;

  // every observed write must be the oldest expected one, in the expected cycle
  always @(negedge clk) begin
    wr_t e;
    for (int k = 0; k < TN; k++) if (o_wr_en[k]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected lane %0d addr %h: got a write, required none", k, o_wr_addr[k*A +: A]);
      end else begin
        e = exp_q.pop_front();
        if (e.lane != k || e.addr != int'(o_wr_addr[k*A +: A]) || e.val != int'(o_wr_val[k*N +: N])
            || e.off != int'(o_wr_off[k*N +: N]) || e.cyc != cyc) begin
          n_bad++;
          $display("FAIL wr_content got lane %0d addr %h val %h off %0d cyc %0d, required lane %0d addr %h val %h off %0d cyc %0d",
                   k, o_wr_addr[k*A +: A], o_wr_val[k*N +: N], o_wr_off[k*N +: N], cyc, e.lane, e.addr, e.val, e.off, e.cyc);
        end
      end
    end
  end

  function automatic logic [TN*N-1:0] rand_brick(int dens);
    logic [TN*N-1:0] r = '0;
    for (int k = 0; k < TN; k++) if ($urandom_range(99) < dens) r[k*N +: N] = 16'($urandom);
    return r;
  endfunction

  task automatic model_beat(input logic [TN*N-1:0] d, input int beat);
    int v;
    for (int k = 0; k < TN; k++) begin
      v = int'(d[k*N +: N]);
      if (v != 0) begin
        if (m_idx[k] + 2 <= m_stride) begin
          exp_q.push_back('{k, (m_base + k*m_stride + m_idx[k]) & 16'hFFFF, v, beat & 16'hFFFF, cyc + 1});
          m_idx[k] += 2;
          m_cnt[k]++;
        end else m_ovf[k] = 1'b1;
      end
    end
  endtask

  task automatic check_final();
    logic [TN*L-1:0] ec;
    logic [TN-1:0] eo;
    for (int k = 0; k < TN; k++) begin
      ec[k*L +: L] = L'(m_cnt[k]);
      eo[k] = m_ovf[k];
    end
    n_cmp += 4;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_after got done %b busy %b, required 0 0", o_done, o_busy); end
    if (o_cnt !== ec) begin n_bad++; $display("FAIL cnt got %h, required %h", o_cnt, ec); end
    if (o_ovf !== eo) begin n_bad++; $display("FAIL ovf got %h, required %h", o_ovf, eo); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL missing_writes got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic do_window(input int len, input int base, input int stride, input int vprob, input int rprob);
    int beat = 0, t = 0, stall = 0;
    bit acc;
    @(negedge clk);
    i_start = 1'b1; i_len = L'(len); i_base_addr = A'(base); i_lane_stride = A'(stride); i_valid = 1'b0;
    m_base = base; m_stride = stride;
    for (int k = 0; k < TN; k++) begin m_idx[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0; end
    @(negedge clk);
    i_start = 1'b0; i_len = 16'($urandom); i_base_addr = 16'($urandom); i_lane_stride = 16'($urandom);
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL busy_start got %b, required 1", o_busy); end
    if (len == 0) begin
      n_cmp++;
      if (o_done !== 1'b1 || o_wr_en !== '0) begin n_bad++; $display("FAIL len0 got done %b wr_en %h, required 1 0", o_done, o_wr_en); end
    end
    while (beat < len && t < 5000) begin
      if (g_start == beat) begin i_start = 1'b1; i_len = 16'd1; i_base_addr = 16'hABCD; i_lane_stride = 16'd2; end
      else i_start = 1'b0;
      if (g_stall == beat && stall < 3) begin i_valid = 1'b1; i_wr_ready = 1'b0; stall++; end
      else begin i_valid = $urandom_range(99) < vprob; i_wr_ready = $urandom_range(99) < rprob; end
      i_data = beat < bq.size() ? bq[beat] : rand_brick(50);
      #1;
      n_cmp++;
      if (o_ready !== i_wr_ready) begin n_bad++; $display("FAIL ready beat %0d got %b, required %b", beat, o_ready, i_wr_ready); end
      acc = i_valid & i_wr_ready;
      if (acc) begin model_beat(i_data, beat); beat++; end
      t++;
      @(negedge clk);
      n_cmp++;
      if (o_done !== (acc && beat == len)) begin n_bad++; $display("FAIL done beat %0d got %b, required %b", beat, o_done, acc && beat == len); end
      if (acc && g_abort == beat) begin
        #2 rst = 1'b1;
        #1 n_cmp++;
        if ({o_ready, o_wr_en, o_busy, o_done, o_ovf, o_cnt} !== '0) begin
          n_bad++;
          $display("FAIL reset_mid got ready %b wr_en %h busy %b done %b ovf %h cnt %h, required all 0", o_ready, o_wr_en, o_busy, o_done, o_ovf, o_cnt);
        end
        exp_q.delete();
        i_valid = 1'b0; i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        g_abort = -1;
        bq.delete();
        return;
      end
    end
    i_valid = 1'b0; i_start = 1'b0;
    if (t >= 5000) begin n_cmp++; n_bad++; $display("FAIL timeout got %0d beats, required %0d", beat, len); end
    @(negedge clk);
    check_final();
    bq.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_ready, o_wr_en, o_busy, o_done, o_ovf, o_cnt} !== '0) begin n_bad++; $display("FAIL reset_state got nonzero outputs, required all 0"); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_idle got busy %b ready %b, required 0 0", o_busy, o_ready); end
  endtask

  task automatic test_basic();
    bq = '{256'd5, 256'd0, 256'd7, 256'd9};
    do_window(4, 'h100, 8, 100, 100);
    n_cmp++;
    if (o_cnt !== 256'd3) begin n_bad++; $display("FAIL basic_cnt got %h, required 3 in lane 0", o_cnt); end
  endtask

  task automatic test_len0();
    do_window(0, 'h40, 8, 100, 100);
  endtask

  task automatic test_stall();
    g_stall = 2;
    do_window(6, 'h300, 16, 100, 100);
    g_stall = -1;
  endtask

  task automatic test_overflow();
    logic [TN*N-1:0] b = '0;
    b[3*N +: N] = 16'h0011;
    bq = '{b, b, b};
    do_window(3, 'h500, 4, 100, 100);
    n_cmp++;
    if (o_ovf !== 16'h0008 || o_cnt[3*L +: L] !== 16'd2) begin n_bad++; $display("FAIL ovf_lane3 got ovf %h cnt %0d, required 0008 2", o_ovf, o_cnt[3*L +: L]); end
  endtask

  task automatic test_reset_mid();
    g_abort = 2;
    do_window(5, 'h700, 8, 100, 100);
    do_window(3, 'h200, 8, 100, 100);
  endtask

  task automatic test_start_in_run();
    g_start = 1;
    do_window(5, 'h900, 10, 100, 100);
    g_start = -1;
  endtask

  task automatic test_random();
    for (int w = 0; w < 12; w++) do_window($urandom_range(20, 1), int'($urandom_range(16'hFFFF)), $urandom_range(12), 70, 70);
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) do_window($urandom_range(6, 1), 16'hFFF0, $urandom_range(8, 2), 100, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_start_in_run();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
